// File: rtl/mips_multi_if.sv
// Unified memory port of the multi-cycle MIPS core: a single request/acknowledge channel
// shared by instruction fetch and data load/store.
interface mips_multi_if #(
  parameter int ADDR_W = 12
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mips_multi.sv
// Multi-cycle MIPS core: one FSM steps FETCH/DECODE/EXEC/MEM/WB over a single memory port
// whose latency is set by mem_ack, and stops in a sticky HALT on illegal or misaligned code.
module mips_multi #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                clock,
  input  logic                reset,
  mips_multi_if.master        mem,
  output logic                halt,
  output logic [31:0]         pc_o,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  state_t       state, state_nx;
  logic [31:0]  pc, ir, a, b, aluout, mdr;
  logic [31:0]  gpr [32];

  logic [5:0]   op, funct;
  logic [4:0]   rs, rt, rd, wb_dst;
  logic [15:0]  imm;
  logic [25:0]  target;
  logic signed [31:0] simm;
  logic [31:0]  ea, wb_data;
  logic         is_r, is_addu, is_subu, is_jr, is_addi, is_ori, is_lui;
  logic         is_lw, is_sw, is_beq, is_j, is_jal, legal, wb_en;

  // Signed overflow of x + y = s: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic signed [31:0] x,
                                   input logic signed [31:0] y,
                                   input logic signed [31:0] s);
    return (x[31] == y[31]) && (s[31] != x[31]);
  endfunction

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];
  assign target = ir[25:0];
  assign simm   = {{16{imm[15]}}, imm};

  assign is_r    = (op == OP_R);
  assign is_addu = is_r && (funct == FN_ADDU);
  assign is_subu = is_r && (funct == FN_SUBU);
  assign is_jr   = is_r && (funct == FN_JR);
  assign is_addi = (op == OP_ADDI);
  assign is_ori  = (op == OP_ORI);
  assign is_lui  = (op == OP_LUI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);
  assign legal   = is_addu | is_subu | is_jr | is_addi | is_ori | is_lui |
                   is_lw | is_sw | is_beq | is_j | is_jal;

  assign ea      = a + simm;
  assign wb_dst  = is_r ? rd : rt;
  assign wb_data = is_lw ? mdr : aluout;
  assign wb_en   = (wb_dst != 5'd0) && !(is_addi && add_ovf($signed(a), simm, $signed(aluout)));

  // Bus outputs decode from state only, so an async reset drops the request at once.
  assign mem.mem_req   = (state == FETCH) || (state == MEM);
  assign mem.mem_we    = (state == MEM) && is_sw;
  assign mem.mem_addr  = (state == FETCH) ? pc[ADDR_W-1:0] :
                         (state == MEM)   ? aluout[ADDR_W-1:0] : '0;
  assign mem.mem_wdata = ((state == MEM) && is_sw) ? b : 32'h0;

  assign halt    = (state == HALT);
  assign pc_o    = pc;
  assign state_o = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      BOOT:    state_nx = FETCH;
      FETCH:   if (mem.mem_ack) state_nx = DECODE;
      DECODE:  state_nx = legal ? EXEC : HALT;
      EXEC: begin
        if (is_lw || is_sw)                      state_nx = (ea[1:0] != 2'b00) ? HALT : MEM;
        else if (is_beq || is_j || is_jal || is_jr) state_nx = FETCH;
        else                                     state_nx = WB;
      end
      MEM:     if (mem.mem_ack) state_nx = is_lw ? WB : FETCH;
      WB:      state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      case (state)
        FETCH: if (mem.mem_ack) begin
          ir <= mem.mem_rdata;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          a      <= gpr[rs];
          b      <= gpr[rt];
          aluout <= pc + {simm[29:0], 2'b00};
        end
        EXEC: begin
          if (is_addu)                       aluout <= a + b;
          else if (is_subu)                  aluout <= a - b;
          else if (is_addi || is_lw || is_sw) aluout <= ea;
          else if (is_ori)                   aluout <= a | {16'h0, imm};
          else if (is_lui)                   aluout <= {imm, 16'h0};
          else if (is_beq) begin
            if (a == b) pc <= aluout;
          end else if (is_j || is_jal) begin
            pc <= {pc[31:28], target, 2'b00};
            if (is_jal) gpr[31] <= pc;
          end else if (is_jr)                pc <= a;
        end
        MEM: if (mem.mem_ack && is_lw) mdr <= mem.mem_rdata;
        WB:  if (wb_en) gpr[wb_dst] <= wb_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multi.sv
// Directed bench for mips_multi: small programs in a zero/variable-wait memory model,
// checked cycle by cycle against hand-computed architectural state.
module tb_mips_multi;

  logic        clock;
  logic        reset;
  logic        halt;
  logic [31:0] pc_o;
  logic [2:0]  state_o;

  mips_multi_if #(.ADDR_W(12)) bus ();

  mips_multi #(.ADDR_W(12), .RESET_PC(32'h0000_3000)) dut (
    .clock   (clock),
    .reset   (reset),
    .mem     (bus),
    .halt    (halt),
    .pc_o    (pc_o),
    .state_o (state_o)
  );

  logic [31:0]   rom [1024];
  logic [31:0]   ram [1024];
  logic [1023:0] ram_vld;
  logic          ram_clr;
  int            wait_n;
  int            wctr;
  int            wr_cycles;
  int            mem_state_cnt;
  int            checks;
  int            errors;
  logic [9:0]    idx;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign idx           = bus.mem_addr[11:2];
  assign bus.mem_ack   = bus.mem_req && (wctr >= wait_n);
  assign bus.mem_rdata = ram_vld[idx] ? ram[idx] : rom[idx];

  always @(posedge clock) begin
    if (ram_clr) ram_vld <= '0;
    else if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
      ram[idx]     <= bus.mem_wdata;
      ram_vld[idx] <= 1'b1;
    end
    if (bus.mem_req && !bus.mem_ack) wctr <= wctr + 1;
    else                             wctr <= 0;
    if (bus.mem_req && bus.mem_we) wr_cycles <= wr_cycles + 1;
    if (state_o == 3'd4) mem_state_cnt <= mem_state_cnt + 1;
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic restart();
    reset   = 1'b0;
    wait_n  = 0;
    ram_clr = 1'b1;
    step(1);
    ram_clr = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
  endtask

  task automatic test_reset();
    restart();
    rom[0]  = enc_i(6'h0d, 5'd0, 5'd1, 16'h1234);
    rom[1]  = enc_i(6'h0f, 5'd0, 5'd2, 16'h7fff);
    rom[2]  = enc_i(6'h0d, 5'd2, 5'd2, 16'hffff);
    rom[3]  = enc_i(6'h08, 5'd2, 5'd3, 16'h0001);
    rom[4]  = enc_i(6'h08, 5'd2, 5'd3, 16'hffff);
    rom[5]  = enc_i(6'h0d, 5'd0, 5'd7, 16'h00ff);
    rom[6]  = enc_r(5'd3, 5'd1, 5'd8, 6'h23);
    rom[7]  = enc_r(5'd1, 5'd1, 5'd9, 6'h21);
    rom[8]  = enc_i(6'h2b, 5'd0, 5'd2, 16'h0008);
    rom[9]  = enc_i(6'h23, 5'd0, 5'd4, 16'h0008);
    rom[10] = enc_r(5'd1, 5'd1, 5'd0, 6'h21);
    step(1);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 12'h000 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0)
      begin errors++; $display("FAIL reset_bus got addr %h we %b wdata %h exp 0", bus.mem_addr, bus.mem_we, bus.mem_wdata); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", halt); end
    checks++; if (pc_o !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc got %h exp 00003000", pc_o); end
  endtask

  task automatic test_alu();
    reset = 1'b1;
    #1;
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL boot_hold got %0d exp 0", state_o); end
    step(1);
    checks++; if (state_o !== 3'd1 || bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h000)
      begin errors++; $display("FAIL first_fetch got st %0d req %b addr %h exp 1 1 000", state_o, bus.mem_req, bus.mem_addr); end
    step(3);
    checks++; if (state_o !== 3'd5 || dut.gpr[1] !== 32'h0)
      begin errors++; $display("FAIL ori_wb_cycle got st %0d r1 %h exp 5 00000000", state_o, dut.gpr[1]); end
    step(1);
    checks++; if (dut.gpr[1] !== 32'h0000_1234) begin errors++; $display("FAIL ori_r1 got %h exp 00001234", dut.gpr[1]); end
    checks++; if (state_o !== 3'd1 || pc_o !== 32'h0000_3004)
      begin errors++; $display("FAIL ori_next got st %0d pc %h exp 1 00003004", state_o, pc_o); end
    step(8);
    checks++; if (dut.gpr[2] !== 32'h7fff_ffff) begin errors++; $display("FAIL seed_r2 got %h exp 7fffffff", dut.gpr[2]); end
    step(4);
    checks++; if (dut.gpr[3] !== 32'h0) begin errors++; $display("FAIL addi_ovf got %h exp 00000000", dut.gpr[3]); end
    step(4);
    checks++; if (dut.gpr[3] !== 32'h7fff_fffe) begin errors++; $display("FAIL addi_m1 got %h exp 7ffffffe", dut.gpr[3]); end
  endtask

  task automatic test_wait();
    wait_n = 3;
    for (int i = 0; i < 4; i++) begin
      checks++; if (state_o !== 3'd1 || bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h014)
        begin errors++; $display("FAIL wait_hold%0d got st %0d req %b addr %h exp 1 1 014", i, state_o, bus.mem_req, bus.mem_addr); end
      if (i < 3) step(1);
    end
    wait_n = 0;
    step(3);
    checks++; if (state_o !== 3'd5) begin errors++; $display("FAIL wait_wb got %0d exp 5", state_o); end
    step(1);
    checks++; if (state_o !== 3'd1 || dut.gpr[7] !== 32'h0000_00ff || pc_o !== 32'h0000_3018)
      begin errors++; $display("FAIL wait_done got st %0d r7 %h pc %h exp 1 000000ff 00003018", state_o, dut.gpr[7], pc_o); end
    step(4);
    checks++; if (dut.gpr[8] !== 32'h7fff_edca) begin errors++; $display("FAIL subu got %h exp 7fffedca", dut.gpr[8]); end
    step(4);
    checks++; if (dut.gpr[9] !== 32'h0000_2468) begin errors++; $display("FAIL addu got %h exp 00002468", dut.gpr[9]); end
  endtask

  task automatic test_mem();
    int wr0;
    wr0 = wr_cycles;
    step(3);
    checks++; if (state_o !== 3'd4 || bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h008 || bus.mem_wdata !== 32'h7fff_ffff)
      begin errors++; $display("FAIL sw_bus got st %0d we %b addr %h wd %h exp 4 1 008 7fffffff", state_o, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    step(1);
    checks++; if (state_o !== 3'd1 || (wr_cycles - wr0) !== 1)
      begin errors++; $display("FAIL sw_done got st %0d writes %0d exp 1 1", state_o, wr_cycles - wr0); end
    step(4);
    checks++; if (state_o !== 3'd5 || dut.gpr[4] !== 32'h0)
      begin errors++; $display("FAIL lw_wb got st %0d r4 %h exp 5 00000000", state_o, dut.gpr[4]); end
    step(1);
    checks++; if (state_o !== 3'd1 || dut.gpr[4] !== 32'h7fff_ffff)
      begin errors++; $display("FAIL lw_r4 got st %0d r4 %h exp 1 7fffffff", state_o, dut.gpr[4]); end
    step(4);
    checks++; if (dut.gpr[0] !== 32'h0 || state_o !== 3'd1)
      begin errors++; $display("FAIL r0_write got r0 %h st %0d exp 00000000 1", dut.gpr[0], state_o); end
  endtask

  task automatic test_branch();
    restart();
    rom[0]  = enc_i(6'h0d, 5'd0, 5'd11, 16'h0005);
    rom[1]  = {6'h02, 26'h000_0c04};
    rom[4]  = enc_i(6'h04, 5'd0, 5'd0, 16'hffff);
    rom[5]  = {6'h03, 26'h000_0c10};
    rom[6]  = 32'hfc00_0000;
    rom[16] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
    reset = 1'b1;
    step(1);
    step(4 + 3);
    checks++; if (state_o !== 3'd1 || pc_o !== 32'h0000_3010 || bus.mem_addr !== 12'h010)
      begin errors++; $display("FAIL j_target got st %0d pc %h addr %h exp 1 00003010 010", state_o, pc_o, bus.mem_addr); end
    step(3);
    checks++; if (state_o !== 3'd1 || pc_o !== 32'h0000_3010)
      begin errors++; $display("FAIL beq_taken got st %0d pc %h exp 1 00003010", state_o, pc_o); end
    rom[4] = enc_i(6'h04, 5'd0, 5'd11, 16'hffff);
    step(3);
    checks++; if (pc_o !== 32'h0000_3014) begin errors++; $display("FAIL beq_not_taken got %h exp 00003014", pc_o); end
    step(3);
    checks++; if (pc_o !== 32'h0000_3040 || bus.mem_addr !== 12'h040 || dut.gpr[31] !== 32'h0000_3018)
      begin errors++; $display("FAIL jal got pc %h addr %h r31 %h exp 00003040 040 00003018", pc_o, bus.mem_addr, dut.gpr[31]); end
    step(3);
    checks++; if (state_o !== 3'd1 || pc_o !== 32'h0000_3018)
      begin errors++; $display("FAIL jr got st %0d pc %h exp 1 00003018", state_o, pc_o); end
    step(2);
    checks++; if (halt !== 1'b1 || state_o !== 3'd6 || pc_o !== 32'h0000_301c || bus.mem_req !== 1'b0)
      begin errors++; $display("FAIL illegal_op got halt %b st %0d pc %h req %b exp 1 6 0000301c 0", halt, state_o, pc_o, bus.mem_req); end
    step(3);
    checks++; if (halt !== 1'b1 || state_o !== 3'd6 || pc_o !== 32'h0000_301c)
      begin errors++; $display("FAIL halt_frozen got halt %b st %0d pc %h exp 1 6 0000301c", halt, state_o, pc_o); end
    reset = 1'b0;
    #1;
    checks++; if (halt !== 1'b0 || state_o !== 3'd0 || pc_o !== 32'h0000_3000)
      begin errors++; $display("FAIL reset_in_halt got halt %b st %0d pc %h exp 0 0 00003000", halt, state_o, pc_o); end
  endtask

  task automatic test_fault();
    int ms0;
    restart();
    rom[0] = enc_i(6'h0d, 5'd0, 5'd5, 16'h0077);
    rom[1] = enc_i(6'h23, 5'd0, 5'd5, 16'h0002);
    reset = 1'b1;
    step(1);
    step(4);
    ms0 = mem_state_cnt;
    step(3);
    checks++; if (halt !== 1'b1 || state_o !== 3'd6 || pc_o !== 32'h0000_3008)
      begin errors++; $display("FAIL misaligned_lw got halt %b st %0d pc %h exp 1 6 00003008", halt, state_o, pc_o); end
    step(2);
    checks++; if ((mem_state_cnt - ms0) !== 0 || bus.mem_req !== 1'b0 || dut.gpr[5] !== 32'h0000_0077)
      begin errors++; $display("FAIL misaligned_noreq got mem %0d req %b r5 %h exp 0 0 00000077", mem_state_cnt - ms0, bus.mem_req, dut.gpr[5]); end
  endtask

  task automatic test_reset_mid_req();
    restart();
    rom[0] = enc_i(6'h0d, 5'd0, 5'd1, 16'h1234);
    wait_n = 100;
    reset  = 1'b1;
    step(3);
    checks++; if (bus.mem_req !== 1'b1 || state_o !== 3'd1)
      begin errors++; $display("FAIL stall_req got req %b st %0d exp 1 1", bus.mem_req, state_o); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || state_o !== 3'd0 || pc_o !== 32'h0000_3000 || dut.gpr[1] !== 32'h0)
      begin errors++; $display("FAIL reset_mid_req got req %b st %0d pc %h r1 %h exp 0 0 00003000 00000000", bus.mem_req, state_o, pc_o, dut.gpr[1]); end
    wait_n = 0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    ram_clr       = 1'b0;
    wait_n        = 0;
    wctr          = 0;
    wr_cycles     = 0;
    mem_state_cnt = 0;
    test_reset();
    test_alu();
    test_wait();
    test_mem();
    test_branch();
    test_fault();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
